pattern_seq_ctrl: RTL
=====================

PATTERN_SEQ_CTRL -- requirements
Module: pattern_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 44, number of pattern table entries per pass (2..63).
REQ-002 SHALL have parameter PRE_DELAY_TICKS, default 20, number of ticks step 0 is held before each pass (1..63).
REQ-003 SHALL have parameter MAX_COUNT, default 9, last value of repeat_count before it wraps to 0 (1..15).
REQ-004 SHALL have port clk_50mhz, input, 1, single clock; all flops on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port tick, input, 1, one-cycle strobe every 0.1 s, synchronous to clk_50mhz.
REQ-007 SHALL have port start, input, 1, start request, sampled every cycle.
REQ-008 SHALL have port stop, input, 1, abort request, sampled every cycle.
REQ-009 SHALL have port pause, input, 1, level freeze request; used only under PAUSE_EN.
REQ-010 SHALL have port hold_ticks, input, 4, hold length of the entry at step_addr, from the pattern table.
REQ-011 SHALL have port step_addr, output, 6, pattern table index to display.
REQ-012 SHALL have port step_valid, output, 1, high = show pattern[step_addr], low = blank LEDs.
REQ-013 SHALL have port repeat_count, output, 4, completed passes modulo MAX_COUNT+1, feeds the 7-seg decoder.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port pass_done, output, 1, one-cycle pulse at the end of each pass.

Function
REQ-016 SHALL implement states IDLE, PRE_DELAY, PLAY, PAUSED; all outputs registered.
REQ-017 SHALL, in IDLE with start=1, go to PRE_DELAY on the next edge with step_addr=0 and delay counter=0; a tick in that cycle is not counted.
REQ-018 SHALL, in PRE_DELAY, increment the delay counter on each tick and go to PLAY on the tick that makes it equal PRE_DELAY_TICKS, with step_addr=0 and hold counter=0.
REQ-019 SHALL, in PLAY, hold each step for max(hold_ticks,1) ticks: on each tick, if hold counter+1 >= max(hold_ticks,1), advance step_addr and clear the hold counter; otherwise increment the hold counter.
REQ-020 SHALL sample hold_ticks combinationally against the current step_addr on every tick; a change of hold_ticks mid-step takes effect on the next tick.
REQ-021 SHALL, when the hold of step NUM_STEPS-1 expires, set step_addr=0, pulse pass_done for exactly that cycle, update repeat_count (MAX_COUNT wraps to 0, else +1), and enter PRE_DELAY with delay counter=0.
REQ-022 SHALL never drive step_addr to NUM_STEPS or above.
REQ-023 SHALL drive step_valid=1 in PRE_DELAY, PLAY and PAUSED, and 0 in IDLE.
REQ-024 SHALL, when stop=1 in any non-IDLE state, go to IDLE on the next edge with step_addr=0 and counters cleared; repeat_count is retained.
REQ-025 SHALL give stop priority over start, pause and tick in the same cycle.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL ignore tick in IDLE.

Reset
REQ-028 SHALL, while reset=1, asynchronously force state=IDLE, step_addr=0, step_valid=0, repeat_count=0, busy=0, pass_done=0, and clear all internal counters.
REQ-029 SHALL, after reset deasserts mid-pass, stay in IDLE until a new start.

Configuration
REQ-030 SHALL, with PAUSE_EN defined: pause=1 in PRE_DELAY or PLAY enters PAUSED on the next edge; counters and step_addr are frozen and ticks ignored; pause=0 returns to the saved state with counters intact; pause and tick in the same cycle means the tick is dropped.
REQ-031 SHALL, without PAUSE_EN, omit PAUSED, ignore the pause port, and keep the port list unchanged.

Verification
REQ-032 SHALL check: reset, start pulse, 20 ticks -> step_addr stays 0 with step_valid=1 through tick 20; tick 21 -> step_addr=1.
REQ-033 SHALL check: hold_ticks=0 except 10 at step 11 -> step_addr=11 for exactly 10 ticks, and step 12 appears on the 10th tick.
REQ-034 SHALL check: ten full passes -> pass_done pulses 10 times, and repeat_count runs 1..9 then 0.
REQ-035 SHALL check: stop and start asserted together at step 30 -> IDLE, step_valid=0, step_addr=0, repeat_count unchanged.
REQ-036 SHALL check (PAUSE_EN): pause held for 50 ticks at step 5 -> step_addr stays 5; after release, step 6 appears on the next tick.
REQ-037 SHALL check: reset asserted between clock edges at step 17 -> outputs at reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/pattern_seq_ctrl.sv
// rtl/pattern_seq_ctrl.sv - LED pattern sequencer: pre-delay, per-step hold, pass counting.
// Optional freeze feature enabled by defining PAUSE_EN.
module pattern_seq_ctrl #(
  parameter int NUM_STEPS       = 44,
  parameter int PRE_DELAY_TICKS = 20,
  parameter int MAX_COUNT       = 9
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [3:0] hold_ticks,
  output logic [5:0] step_addr,
  output logic       step_valid,
  output logic [3:0] repeat_count,
  output logic       busy,
  output logic       pass_done
);

`ifdef PAUSE_EN
  typedef enum logic [1:0] {IDLE, PRE_DELAY, PLAY, PAUSED} state_t;
  state_t saved_state, saved_n;
`else
  typedef enum logic [1:0] {IDLE, PRE_DELAY, PLAY} state_t;
  logic unused_pause;
  assign unused_pause = pause;
`endif

  localparam logic [5:0] LAST_STEP = 6'(NUM_STEPS - 1);
  localparam logic [5:0] PRE_TICKS = 6'(PRE_DELAY_TICKS);
  localparam logic [3:0] MAX_REP   = 4'(MAX_COUNT);

  state_t     state, state_n;
  logic [5:0] delay_cnt, delay_n;
  logic [3:0] hold_cnt, hold_n;
  logic [5:0] step_n;
  logic [3:0] rep_n;
  logic       pd_n;
  logic [3:0] hold_limit;
  logic       hold_done;

  // A zero hold length still shows the step for one tick.
  assign hold_limit = (hold_ticks == 4'd0) ? 4'd1 : hold_ticks;
  assign hold_done  = ({1'b0, hold_cnt} + 5'd1) >= {1'b0, hold_limit};

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      delay_cnt    <= 6'd0;
      hold_cnt     <= 4'd0;
      step_addr    <= 6'd0;
      step_valid   <= 1'b0;
      repeat_count <= 4'd0;
      busy         <= 1'b0;
      pass_done    <= 1'b0;
`ifdef PAUSE_EN
      saved_state  <= IDLE;
`endif
    end else begin
      state        <= state_n;
      delay_cnt    <= delay_n;
      hold_cnt     <= hold_n;
      step_addr    <= step_n;
      step_valid   <= (state_n != IDLE);
      repeat_count <= rep_n;
      busy         <= (state_n != IDLE);
      pass_done    <= pd_n;
`ifdef PAUSE_EN
      saved_state  <= saved_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    delay_n = delay_cnt;
    hold_n  = hold_cnt;
    step_n  = step_addr;
    rep_n   = repeat_count;
    pd_n    = 1'b0;
`ifdef PAUSE_EN
    saved_n = saved_state;
`endif
    if (state == IDLE) begin
      if (start) begin
        state_n = PRE_DELAY;
        step_n  = 6'd0;
        delay_n = 6'd0;
        hold_n  = 4'd0;
      end
    end else if (stop) begin
      state_n = IDLE;
      step_n  = 6'd0;
      delay_n = 6'd0;
      hold_n  = 4'd0;
`ifdef PAUSE_EN
    end else if (state == PAUSED) begin
      if (!pause) state_n = saved_state;
    end else if (pause) begin
      saved_n = state;
      state_n = PAUSED;
`endif
    end else if (tick) begin
      if (state == PRE_DELAY) begin
        delay_n = delay_cnt + 6'd1;
        if (delay_cnt + 6'd1 == PRE_TICKS) begin
          state_n = PLAY;
          hold_n  = 4'd0;
        end
      end else if (hold_done) begin
        hold_n = 4'd0;
        if (step_addr == LAST_STEP) begin
          // End of pass: wrap the table and count the pass.
          step_n  = 6'd0;
          pd_n    = 1'b1;
          rep_n   = (repeat_count == MAX_REP) ? 4'd0 : repeat_count + 4'd1;
          state_n = PRE_DELAY;
          delay_n = 6'd0;
        end else begin
          step_n = step_addr + 6'd1;
        end
      end else begin
        hold_n = hold_cnt + 4'd1;
      end
    end
  end

endmodule
